fib_sequencer: RTL and testbench

Control block that drives the 4-bit ALU to generate the Fibonacci series. On `start` it steps the ALU with ADD operations, one per cycle. It streams each term out with a valid strobe and an index. It stops after a requested number of terms, or earlier when the next term would wrap the SIZE-bit datapath. It sits beside the ALU in the calculator top level: it owns `in1`/`in2`/`alu_opcode` and consumes `out`.

---
 rtl/fib_pkg.sv | 24 ++
 rtl/fib_sequencer.sv | 161 ++++++++++++++++
 tb/tb_fib_sequencer.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/fib_pkg.sv
// Shared constants for the Fibonacci sequencer and the ALU beside it:
// sequencer state encoding and the ALU opcodes it drives.
package fib_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } fib_state_e;

  localparam logic [2:0] OP_IDLE = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;

  // Opcode presented to the ALU while in a given state.
  function automatic logic [2:0] opcode_for(input fib_state_e st);
    logic [2:0] op;
    case (st)
      ST_RUN:  op = OP_ADD;
      default: op = OP_IDLE;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/fib_sequencer.sv
// Fibonacci sequencer: steps an external ALU with ADDs, one per cycle,
// streaming F(0..N-1) with a valid strobe and index. Stops early when the
// next term would no longer fit in SIZE bits.
module fib_sequencer
  import fib_pkg::*;
#(
  parameter int SIZE  = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] n_terms,
  output logic [SIZE-1:0]  alu_in1,
  output logic [SIZE-1:0]  alu_in2,
  output logic [2:0]       alu_opcode,
  input  logic [SIZE-1:0]  alu_out,
  output logic             busy,
  output logic             term_valid,
  output logic [SIZE-1:0]  term,
  output logic [CNT_W-1:0] term_idx,
  output logic             done,
  output logic             overflow
);

  fib_state_e       state_q, state_d;
  logic [CNT_W-1:0] n_q, n_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [SIZE-1:0]  a_q, a_d;
  logic [SIZE-1:0]  b_q, b_d;
  logic             a_wrap_q, a_wrap_d;
  logic             b_wrap_q, b_wrap_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             term_valid_q, term_valid_d;
  logic [SIZE-1:0]  term_q, term_d;
  logic [CNT_W-1:0] term_idx_q, term_idx_d;
  logic             overflow_q, overflow_d;
  logic [2:0]       opcode_q, opcode_d;
  logic             last_s;
  logic             sum_wrap_s;

  // Last requested term reached; a sum smaller than its addend means the add wrapped.
  assign last_s     = (idx_q == (n_q - CNT_W'(1)));
  assign sum_wrap_s = (alu_out < b_q);

  // Next-state, datapath update and output strobes.
  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    idx_d        = idx_q;
    a_d          = a_q;
    b_d          = b_q;
    a_wrap_d     = a_wrap_q;
    b_wrap_d     = b_wrap_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    term_valid_d = 1'b0;
    term_d       = term_q;
    term_idx_d   = term_idx_q;
    overflow_d   = overflow_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          n_d        = n_terms;
          a_d        = SIZE'(0);
          b_d        = SIZE'(1);
          idx_d      = CNT_W'(0);
          a_wrap_d   = 1'b0;
          b_wrap_d   = 1'b0;
          busy_d     = 1'b1;
          overflow_d = 1'b0;
          if (n_terms == CNT_W'(0)) begin
            state_d = ST_FIN;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (a_wrap_q) begin
          // The pending term did not fit: stop without emitting it.
          overflow_d = 1'b1;
          state_d    = ST_FIN;
        end else begin
          term_d       = a_q;
          term_idx_d   = idx_q;
          term_valid_d = 1'b1;
          a_d          = b_q;
          a_wrap_d     = b_wrap_q;
          b_d          = alu_out;
          b_wrap_d     = b_wrap_q | sum_wrap_s;
          idx_d        = idx_q + CNT_W'(1);
          if (last_s) begin
            state_d = ST_FIN;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
    opcode_d = opcode_for(state_d);
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      n_q          <= CNT_W'(0);
      idx_q        <= CNT_W'(0);
      a_q          <= SIZE'(0);
      b_q          <= SIZE'(1);
      a_wrap_q     <= 1'b0;
      b_wrap_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      term_valid_q <= 1'b0;
      term_q       <= SIZE'(0);
      term_idx_q   <= CNT_W'(0);
      overflow_q   <= 1'b0;
      opcode_q     <= OP_IDLE;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      idx_q        <= idx_d;
      a_q          <= a_d;
      b_q          <= b_d;
      a_wrap_q     <= a_wrap_d;
      b_wrap_q     <= b_wrap_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      term_valid_q <= term_valid_d;
      term_q       <= term_d;
      term_idx_q   <= term_idx_d;
      overflow_q   <= overflow_d;
      opcode_q     <= opcode_d;
    end
  end

  assign alu_in1    = a_q;
  assign alu_in2    = b_q;
  assign alu_opcode = opcode_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign term_valid = term_valid_q;
  assign term       = term_q;
  assign term_idx   = term_idx_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_fib_sequencer.sv
// Table-driven bench for fib_sequencer. A 4-bit wrapping adder stands in
// for the ALU; expected terms are hand-computed in the vector table.
module tb_fib_sequencer;
  import fib_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] n_terms;
  logic [3:0] alu_in1;
  logic [3:0] alu_in2;
  logic [2:0] alu_opcode;
  logic [3:0] alu_out;
  logic       busy;
  logic       term_valid;
  logic [3:0] term;
  logic [3:0] term_idx;
  logic       done;
  logic       overflow;

  int checks;
  int failures;
  int cur_vec;
  int cur_cyc;

  typedef struct {
    logic [3:0]  n;
    int          cnt;    // terms expected to be emitted
    logic        ovf;    // run expected to end on wrap
    logic [63:0] terms;  // term i in nibble i
    logic        poke;   // hold start high through RUN and FIN
  } vec_t;

  vec_t vecs[7];

  fib_sequencer #(.SIZE(4), .CNT_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .n_terms    (n_terms),
    .alu_in1    (alu_in1),
    .alu_in2    (alu_in2),
    .alu_opcode (alu_opcode),
    .alu_out    (alu_out),
    .busy       (busy),
    .term_valid (term_valid),
    .term       (term),
    .term_idx   (term_idx),
    .done       (done),
    .overflow   (overflow)
  );

  // Wrapping 4-bit adder standing in for the ALU.
  assign alu_out = alu_in1 + alu_in2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s vec=%0d cyc=%0d got=%0d expected=%0d", name, cur_vec, cur_cyc, act, exp);
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_done", 16'(done), 16'd0);
    chk("rst_valid", 16'(term_valid), 16'd0);
    chk("rst_ovf", 16'(overflow), 16'd0);
    chk("rst_term", 16'(term), 16'd0);
    chk("rst_idx", 16'(term_idx), 16'd0);
    chk("rst_in1", 16'(alu_in1), 16'd0);
    chk("rst_in2", 16'(alu_in2), 16'd1);
    chk("rst_op", 16'(alu_opcode), 16'(OP_IDLE));
  endtask

  // Start one run and check every output on every cycle until done.
  // Cycle c is sampled 1 time unit after the c-th edge past acceptance.
  task automatic run_vec(input vec_t v);
    int m;
    int run_len;
    int done_c;
    m       = v.cnt;
    run_len = v.ovf ? m + 1 : m;
    done_c  = run_len + 1;
    @(negedge clk);
    start   = 1'b1;
    n_terms = v.n;
    @(posedge clk);
    #1;
    for (int c = 0; c <= done_c; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #1;
      end
      cur_cyc = c;
      chk("busy", 16'(busy), 16'(c < done_c));
      chk("done", 16'(done), 16'(c == done_c));
      chk("term_valid", 16'(term_valid), 16'(c >= 1 && c <= m));
      chk("overflow", 16'(overflow), 16'(v.ovf && c >= run_len));
      chk("opcode", 16'(alu_opcode), 16'((c < run_len) ? OP_ADD : OP_IDLE));
      if (c >= 1 && c <= m) begin
        chk("term", 16'(term), 16'(v.terms[4*(c-1) +: 4]));
        chk("term_idx", 16'(term_idx), 16'(c - 1));
      end
      if (c > m && m > 0) begin
        chk("term_hold", 16'(term), 16'(v.terms[4*(m-1) +: 4]));
        chk("idx_hold", 16'(term_idx), 16'(m - 1));
      end
      if (c < done_c) begin
        @(negedge clk);
        start   = v.poke;
        n_terms = v.poke ? 4'd2 : v.n;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    cur_vec  = -1;
    cur_cyc  = 0;
    start    = 1'b0;
    n_terms  = 4'd0;
    rst_n    = 1'b0;

    vecs[0] = '{4'd6,  6, 1'b0, 64'h0000_0000_0053_2110, 1'b0};
    vecs[1] = '{4'd15, 8, 1'b1, 64'h0000_0000_D853_2110, 1'b0};
    vecs[2] = '{4'd6,  6, 1'b0, 64'h0000_0000_0053_2110, 1'b1};
    vecs[3] = '{4'd0,  0, 1'b0, 64'h0,                   1'b0};
    vecs[4] = '{4'd1,  1, 1'b0, 64'h0,                   1'b0};
    vecs[5] = '{4'd3,  3, 1'b0, 64'h110,                 1'b0};
    vecs[6] = '{4'd2,  2, 1'b0, 64'h10,                  1'b0};

    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    // Plain run, overflow run, run with ignored starts (clears overflow),
    // zero-length run, then two back-to-back runs.
    for (int i = 0; i < 6; i++) begin
      cur_vec = i;
      run_vec(vecs[i]);
    end

    // Asynchronous reset mid-run, right after the third term.
    cur_vec = 100;
    @(negedge clk);
    start   = 1'b1;
    n_terms = 4'd6;
    @(posedge clk);
    #1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    cur_cyc = 3;
    chk("pre_rst_valid", 16'(term_valid), 16'd1);
    chk("pre_rst_term", 16'(term), 16'd1);
    chk("pre_rst_idx", 16'(term_idx), 16'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs();
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      cur_cyc = 4 + k;
      chk("rst_no_done", 16'(done), 16'd0);
      chk("rst_no_busy", 16'(busy), 16'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    cur_vec = 6;
    run_vec(vecs[6]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
